// File: rtl/dm_port_arbiter.sv
// dm_port_arbiter
// Shares the single-port data memory between the processor core and the
// loader/debug port. Round-robin arbitration with optional locked bursts of
// up to MAX_BURST grants. Grants are combinational. Read data from the memory
// arrives one cycle after the grant and is steered back with a registered
// per-requester valid. A saturating counter records cycles in which any
// request was denied.
module dm_port_arbiter #(
  parameter int AW        = 8,
  parameter int DW        = 8,
  parameter int MAX_BURST = 4,
  parameter int CW        = 16
) (
  input  logic          clk,
  input  logic          reset,
  // core port
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  input  logic          c_lock,
  output logic          c_gnt,
  output logic          c_rvalid,
  output logic [DW-1:0] c_rdata,
  // loader port
  input  logic          l_req,
  input  logic          l_we,
  input  logic [AW-1:0] l_addr,
  input  logic [DW-1:0] l_wdata,
  input  logic          l_lock,
  output logic          l_gnt,
  output logic          l_rvalid,
  output logic [DW-1:0] l_rdata,
  // memory port
  output logic          m_en,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  // statistics
  output logic [CW-1:0] stall_cnt
);

  // Burst counter only has to reach MAX_BURST-1 before the burst is closed.
  localparam int BCW = $clog2(MAX_BURST);
  localparam logic [BCW-1:0] BURST_LAST = BCW'(MAX_BURST - 1);

  localparam logic SRC_CORE   = 1'b0;
  localparam logic SRC_LOADER = 1'b1;

  typedef enum logic [1:0] {
    ST_ARB     = 2'd0,
    ST_BURST_C = 2'd1,
    ST_BURST_L = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             last_q, last_d;
  logic [BCW-1:0]   burst_cnt_q, burst_cnt_d;
  logic             c_rvalid_q, l_rvalid_q;
  logic [CW-1:0]    stall_q, stall_d;
  logic             deny;

  // Saturating increment: the counter sticks at all-ones instead of wrapping.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    if (v == {CW{1'b1}}) begin
      return v;
    end
    return v + CW'(1);
  endfunction

  // Grant decision: at most one winner per cycle, nothing while in reset.
  always_comb begin
    c_gnt = 1'b0;
    l_gnt = 1'b0;
    if (!reset) begin
      unique case (state_q)
        ST_BURST_C: begin
          // Burst owner keeps priority; the loader fills any gap immediately.
          if (c_req) begin
            c_gnt = 1'b1;
          end else if (l_req) begin
            l_gnt = 1'b1;
          end
        end
        ST_BURST_L: begin
          if (l_req) begin
            l_gnt = 1'b1;
          end else if (c_req) begin
            c_gnt = 1'b1;
          end
        end
        default: begin
          // Round robin: on a tie the side that did not win last goes first.
          if (c_req && l_req) begin
            if (last_q == SRC_LOADER) begin
              c_gnt = 1'b1;
            end else begin
              l_gnt = 1'b1;
            end
          end else begin
            c_gnt = c_req;
            l_gnt = l_req;
          end
        end
      endcase
    end
  end

  // Memory mux: forward the winner's command, drive zeros when idle.
  always_comb begin
    m_en    = c_gnt | l_gnt;
    m_we    = 1'b0;
    m_addr  = '0;
    m_wdata = '0;
    if (c_gnt) begin
      m_we    = c_we;
      m_addr  = c_addr;
      m_wdata = c_wdata;
    end else if (l_gnt) begin
      m_we    = l_we;
      m_addr  = l_addr;
      m_wdata = l_wdata;
    end
  end

  // Next-state logic for arbitration state, round-robin pointer and burst length.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    burst_cnt_d = burst_cnt_q;
    if (c_gnt) begin
      last_d = SRC_CORE;
      if (state_q == ST_BURST_C) begin
        if (!c_lock || (burst_cnt_q == BURST_LAST)) begin
          state_d     = ST_ARB;
          burst_cnt_d = '0;
        end else begin
          burst_cnt_d = burst_cnt_q + BCW'(1);
        end
      end else if (state_q == ST_ARB) begin
        if (c_lock) begin
          state_d     = ST_BURST_C;
          burst_cnt_d = BCW'(1);
        end
      end else begin
        // Loader burst interrupted by a core grant.
        state_d     = ST_ARB;
        burst_cnt_d = '0;
      end
    end else if (l_gnt) begin
      last_d = SRC_LOADER;
      if (state_q == ST_BURST_L) begin
        if (!l_lock || (burst_cnt_q == BURST_LAST)) begin
          state_d     = ST_ARB;
          burst_cnt_d = '0;
        end else begin
          burst_cnt_d = burst_cnt_q + BCW'(1);
        end
      end else if (state_q == ST_ARB) begin
        if (l_lock) begin
          state_d     = ST_BURST_L;
          burst_cnt_d = BCW'(1);
        end
      end else begin
        // Core burst interrupted by a loader grant.
        state_d     = ST_ARB;
        burst_cnt_d = '0;
      end
    end else if (state_q != ST_ARB) begin
      // Nobody asked: any open burst is closed.
      state_d     = ST_ARB;
      burst_cnt_d = '0;
    end
  end

  // A cycle counts as a stall when any requester was left waiting.
  always_comb begin
    deny    = (c_req & ~c_gnt) | (l_req & ~l_gnt);
    stall_d = deny ? sat_inc(stall_q) : stall_q;
  end

  // Arbitration state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_ARB;
      last_q      <= SRC_LOADER;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  // Read-return valids: a granted read produces data on the next cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      c_rvalid_q <= 1'b0;
      l_rvalid_q <= 1'b0;
    end else begin
      c_rvalid_q <= c_gnt & ~c_we;
      l_rvalid_q <= l_gnt & ~l_we;
    end
  end

  // Saturating stall counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  // Both consumers see the memory read bus; each qualifies it with its own valid.
  assign c_rvalid  = c_rvalid_q;
  assign l_rvalid  = l_rvalid_q;
  assign c_rdata   = m_rdata;
  assign l_rdata   = m_rdata;
  assign stall_cnt = stall_q;

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Directed bench for dm_port_arbiter with a small memory model and a read
// scoreboard. A second instance with a 4-bit stall counter shares the inputs.
module tb_dm_port_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       c_req = 1'b0, c_we = 1'b0, c_lock = 1'b0;
  logic [7:0] c_addr = '0, c_wdata = '0;
  logic       l_req = 1'b0, l_we = 1'b0, l_lock = 1'b0;
  logic [7:0] l_addr = '0, l_wdata = '0;
  logic       c_gnt, c_rvalid, l_gnt, l_rvalid;
  logic [7:0] c_rdata, l_rdata;
  logic       m_en, m_we;
  logic [7:0] m_addr, m_wdata;
  logic [7:0] m_rdata;
  logic [15:0] stall_cnt;

  logic       c_gnt4, c_rvalid4, l_gnt4, l_rvalid4;
  logic [7:0] c_rdata4, l_rdata4;
  logic       m_en4, m_we4;
  logic [7:0] m_addr4, m_wdata4;
  logic [3:0] stall4;

  always #5 clk = ~clk;

  dm_port_arbiter #(.AW(8), .DW(8), .MAX_BURST(4), .CW(16)) dut (
    .clk(clk), .reset(reset),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata), .c_lock(c_lock),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata), .l_lock(l_lock),
    .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata),
    .stall_cnt(stall_cnt)
  );

  dm_port_arbiter #(.AW(8), .DW(8), .MAX_BURST(4), .CW(4)) dut4 (
    .clk(clk), .reset(reset),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata), .c_lock(c_lock),
    .c_gnt(c_gnt4), .c_rvalid(c_rvalid4), .c_rdata(c_rdata4),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata), .l_lock(l_lock),
    .l_gnt(l_gnt4), .l_rvalid(l_rvalid4), .l_rdata(l_rdata4),
    .m_en(m_en4), .m_we(m_we4), .m_addr(m_addr4), .m_wdata(m_wdata4), .m_rdata(m_rdata),
    .stall_cnt(stall4)
  );

  // Single-port memory model with one-cycle read latency.
  logic [7:0] mem [0:255];
  always @(posedge clk) begin
    if (m_en) begin
      if (m_we) mem[m_addr] <= m_wdata;
      else      m_rdata <= mem[m_addr];
    end
  end

  typedef struct {
    bit         who;
    logic [7:0] data;
  } sb_t;

  sb_t        sb[$];
  logic [7:0] shadow [0:255];
  int         total = 0;
  int         bad = 0;
  int         exp_stall = 0;
  bit         exp_crv = 1'b0;
  bit         exp_lrv = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One cycle of stimulus, applied at the current negedge.
  // eg: 0 = no grant expected, 1 = core, 2 = loader.
  task automatic step_now(input logic cr, input logic cw, input logic [7:0] ca, input logic [7:0] cd,
                          input logic ck, input logic lr, input logic lw, input logic [7:0] la,
                          input logic [7:0] ld, input logic lk, input int eg);
    sb_t e;
    chk("c_rvalid", c_rvalid, exp_crv);
    chk("l_rvalid", l_rvalid, exp_lrv);
    if (exp_crv || exp_lrv) begin
      e = sb.pop_front();
      if (e.who) chk("l_rdata", l_rdata, e.data);
      else       chk("c_rdata", c_rdata, e.data);
    end
    chk("stall_cnt", stall_cnt, exp_stall);
    chk("stall4", stall4, (exp_stall > 15) ? 15 : exp_stall);
    c_req = cr; c_we = cw; c_addr = ca; c_wdata = cd; c_lock = ck;
    l_req = lr; l_we = lw; l_addr = la; l_wdata = ld; l_lock = lk;
    #1;
    chk("c_gnt", c_gnt, eg == 1);
    chk("l_gnt", l_gnt, eg == 2);
    chk("m_en", m_en, eg != 0);
    chk("c_gnt4", c_gnt4, eg == 1);
    exp_crv = 1'b0;
    exp_lrv = 1'b0;
    if (eg == 1) begin
      chk("m_we_c", m_we, cw);
      chk("m_addr_c", m_addr, ca);
      if (cw) begin
        chk("m_wdata_c", m_wdata, cd);
        shadow[ca] = cd;
      end else begin
        sb.push_back('{who: 1'b0, data: shadow[ca]});
        exp_crv = 1'b1;
      end
    end else if (eg == 2) begin
      chk("m_we_l", m_we, lw);
      chk("m_addr_l", m_addr, la);
      if (lw) begin
        chk("m_wdata_l", m_wdata, ld);
        shadow[la] = ld;
      end else begin
        sb.push_back('{who: 1'b1, data: shadow[la]});
        exp_lrv = 1'b1;
      end
    end else begin
      chk("m_idle", {m_we, m_addr, m_wdata}, 0);
    end
    if ((cr && eg != 1) || (lr && eg != 2)) begin
      if (exp_stall < 65535) exp_stall++;
    end
  endtask

  task automatic step(input logic cr, input logic cw, input logic [7:0] ca, input logic [7:0] cd,
                      input logic ck, input logic lr, input logic lw, input logic [7:0] la,
                      input logic [7:0] ld, input logic lk, input int eg);
    @(negedge clk);
    step_now(cr, cw, ca, cd, ck, lr, lw, la, ld, lk, eg);
  endtask

  task automatic idle();
    step(0, 0, 8'd0, 8'd0, 0, 0, 0, 8'd0, 8'd0, 0, 0);
  endtask

  task automatic do_reset();
    idle();
    @(negedge clk);
    reset = 1'b1;
    c_req = 1'b0; l_req = 1'b0; c_lock = 1'b0; l_lock = 1'b0;
    @(negedge clk);
    chk("rst_c_rvalid", c_rvalid, 0);
    chk("rst_l_rvalid", l_rvalid, 0);
    chk("rst_stall", stall_cnt, 0);
    reset = 1'b0;
    exp_stall = 0;
    exp_crv = 1'b0;
    exp_lrv = 1'b0;
    sb.delete();
  endtask

  int ci;
  int exp3 [10] = '{1, 1, 1, 1, 2, 1, 1, 1, 1, 2};

  initial begin
    // Reset and core-only write/read, then loader preload.
    do_reset();
    step(1, 1, 8'd2, 8'h55, 0, 0, 0, 8'd0, 8'd0, 0, 1);
    step(1, 0, 8'd2, 8'h00, 0, 0, 0, 8'd0, 8'd0, 0, 1);
    for (int i = 10; i < 16; i++)
      step(0, 0, 8'd0, 8'd0, 0, 1, 1, 8'(i), 8'(8'h10 + i), 0, 2);
    step(0, 0, 8'd0, 8'd0, 0, 1, 1, 8'd20, 8'hC3, 0, 2);
    idle();

    // Both read every cycle, no lock: strict alternation starting with core.
    do_reset();
    for (int i = 0; i < 6; i++)
      step(1, 0, 8'd2, 8'd0, 0, 1, 0, 8'd20, 8'd0, 0, (i % 2 == 0) ? 1 : 2);
    idle();

    // Core locked burst against a requesting loader: 4 core, 1 loader, repeat.
    do_reset();
    ci = 0;
    for (int k = 0; k < 10; k++) begin
      step(1, 0, 8'(10 + (ci % 6)), 8'd0, 1, 1, 0, 8'd20, 8'd0, 0, exp3[k]);
      if (exp3[k] == 1) ci++;
    end
    idle();

    // Core drops its request mid-burst: loader is granted, state returns to ARB.
    do_reset();
    step(1, 0, 8'd10, 8'd0, 1, 0, 0, 8'd0, 8'd0, 0, 1);
    step(0, 0, 8'd0, 8'd0, 0, 1, 0, 8'd20, 8'd0, 1, 2);
    step(1, 0, 8'd11, 8'd0, 0, 1, 0, 8'd20, 8'd0, 0, 1);
    step(1, 0, 8'd11, 8'd0, 0, 1, 0, 8'd20, 8'd0, 0, 2);
    idle();

    // Reset right after a granted read inside a burst.
    do_reset();
    step(1, 0, 8'd11, 8'd0, 1, 1, 0, 8'd20, 8'd0, 0, 1);
    step(1, 0, 8'd2, 8'd0, 1, 1, 0, 8'd20, 8'd0, 0, 1);
    #1;
    reset = 1'b1;
    void'(sb.pop_back());
    exp_crv = 1'b0;
    #1;
    chk("rst_c_gnt", c_gnt, 0);
    chk("rst_l_gnt", l_gnt, 0);
    chk("rst_m_en", m_en, 0);
    chk("rst_m_we", m_we, 0);
    @(negedge clk);
    chk("rst_no_c_rvalid", c_rvalid, 0);
    chk("rst_no_l_rvalid", l_rvalid, 0);
    chk("rst_hold_c_gnt", c_gnt, 0);
    chk("rst_hold_m_en", m_en, 0);
    chk("rst_stall0", stall_cnt, 0);
    reset = 1'b0;
    exp_stall = 0;
    step_now(1, 0, 8'd2, 8'd0, 0, 1, 0, 8'd20, 8'd0, 0, 1);
    step(1, 0, 8'd2, 8'd0, 0, 1, 0, 8'd20, 8'd0, 0, 2);
    idle();

    // Sustained contention: 16-bit counter reaches 20, 4-bit counter pins at 15.
    do_reset();
    for (int i = 0; i < 20; i++)
      step(1, 0, 8'd2, 8'd0, 0, 1, 0, 8'd20, 8'd0, 0, (i % 2 == 0) ? 1 : 2);
    idle();
    idle();
    chk("sb_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
